// File: rtl/stream_source_gen.sv
`default_nettype none
// ============================================================================
// Module   : stream_source_gen
// Summary  : Valid/ready packet traffic source with selectable data patterns.
//            Define STREAM_SRC_GAP_EN to insert PKT_GAP idle cycles between packets.
// Revision : 1.0 - initial release
// ============================================================================
module stream_source_gen #(
  parameter int WIDTH    = 8,
  parameter int PKT_LEN  = 16,
  parameter int NUM_PKTS = 4,
  parameter int SEED     = 1,
  parameter int PKT_GAP  = 2
) (
  input  logic             clk,
  input  logic             s_rst,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] data_out,
  output logic             last,
  output logic             busy,
  output logic             done
);

  localparam int BW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam int PW = (NUM_PKTS > 0) ? $clog2(NUM_PKTS + 1) : 1;
  localparam logic [31:0]      SEED_VEC  = 32'(SEED);
  localparam logic [15:0]      LFSR_INIT = (SEED_VEC[15:0] == 16'd0) ? 16'd1 : SEED_VEC[15:0];
  localparam logic [WIDTH-1:0] CONST_VAL = SEED_VEC[WIDTH-1:0];
  localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);
  localparam logic [BW-1:0]    BEAT_MAX  = BW'(PKT_LEN - 1);
  localparam logic [PW-1:0]    PKT_FINAL = PW'(NUM_PKTS - 1);

`ifdef STREAM_SRC_GAP_EN
  localparam int GW = (PKT_GAP > 1) ? $clog2(PKT_GAP) : 1;
  localparam logic [GW-1:0] GAP_MAX = GW'(PKT_GAP - 1);
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_GAP = 2'd2, S_DONE = 2'd3} state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd3} state_t;
`endif

  if (WIDTH < 1 || WIDTH > 32 || PKT_LEN < 1 || NUM_PKTS < 0 || PKT_GAP < 0) begin : g_param_range_error
  end

  state_t           state_q, state_d;
  logic [1:0]       mode_q, mode_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             last_q, last_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [BW-1:0]    beat_q, beat_d;
  logic [PW-1:0]    pkt_q, pkt_d;
  logic [15:0]      lfsr_q, lfsr_d;
`ifdef STREAM_SRC_GAP_EN
  logic [GW-1:0]    gap_q, gap_d;
`endif

  logic             hs;
  logic [15:0]      lfsr_step_w;
  logic [WIDTH-1:0] lf_cur, lf_nxt;

  // x^16+x^14+x^13+x^11+1, Fibonacci form shifting towards the MSB
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  function automatic logic [WIDTH-1:0] pat_next(input logic [1:0] m, input logic [WIDTH-1:0] cur,
                                                input logic [WIDTH-1:0] lfv);
    case (m)
      2'd0:    return cur + ONE;
      2'd1:    return CONST_VAL;
      2'd2:    return (cur << 1) | (cur >> (WIDTH - 1));
      default: return lfv;
    endcase
  endfunction

  assign hs          = valid_q & ready;
  assign lfsr_step_w = lfsr_step(lfsr_q);

  if (WIDTH > 16) begin : g_lfsr_wide
    assign lf_cur = {{(WIDTH-16){1'b0}}, lfsr_q};
    assign lf_nxt = {{(WIDTH-16){1'b0}}, lfsr_step_w};
  end else begin : g_lfsr_narrow
    assign lf_cur = lfsr_q[WIDTH-1:0];
    assign lf_nxt = lfsr_step_w[WIDTH-1:0];
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    data_d  = data_q;
    valid_d = valid_q;
    last_d  = last_q;
    busy_d  = busy_q;
    done_d  = done_q;
    beat_d  = beat_q;
    pkt_d   = pkt_q;
    lfsr_d  = lfsr_q;
`ifdef STREAM_SRC_GAP_EN
    gap_d   = gap_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_RUN;
          mode_d  = mode;
          beat_d  = '0;
          pkt_d   = '0;
          lfsr_d  = LFSR_INIT;
          data_d  = (mode == 2'd2) ? ONE : pat_next(mode, '0, LFSR_INIT[WIDTH-1:0] | '0);
          last_d  = (PKT_LEN == 1);
          valid_d = 1'b1;
          busy_d  = 1'b1;
          done_d  = 1'b0;
        end
      end
      S_RUN: begin
        if (hs) begin
          lfsr_d = lfsr_step_w;
          if (last_q) begin
            beat_d = '0;
            pkt_d  = pkt_q + PW'(1);
            last_d = (PKT_LEN == 1);
            if ((NUM_PKTS != 0) && (pkt_q == PKT_FINAL)) begin
              state_d = S_DONE;
              valid_d = 1'b0;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end else begin
              data_d = pat_next(mode_q, data_q, lf_nxt);
`ifdef STREAM_SRC_GAP_EN
              // data_out freezes during the gap; the next beat is built on exit
              if (PKT_GAP > 0) begin
                data_d  = data_q;
                valid_d = 1'b0;
                gap_d   = GAP_MAX;
                state_d = S_GAP;
              end
`endif
            end
          end else begin
            beat_d = beat_q + BW'(1);
            last_d = (beat_d == BEAT_MAX);
            data_d = pat_next(mode_q, data_q, lf_nxt);
          end
        end
      end
`ifdef STREAM_SRC_GAP_EN
      S_GAP: begin
        if (gap_q == '0) begin
          state_d = S_RUN;
          valid_d = 1'b1;
          data_d  = pat_next(mode_q, data_q, lf_cur);
        end else begin
          gap_d = gap_q - GW'(1);
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (s_rst) begin
      state_q <= S_IDLE;
      mode_q  <= 2'd0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      beat_q  <= '0;
      pkt_q   <= '0;
      lfsr_q  <= LFSR_INIT;
`ifdef STREAM_SRC_GAP_EN
      gap_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      beat_q  <= beat_d;
      pkt_q   <= pkt_d;
      lfsr_q  <= lfsr_d;
`ifdef STREAM_SRC_GAP_EN
      gap_q   <= gap_d;
`endif
    end
  end

  assign valid    = valid_q;
  assign data_out = data_q;
  assign last     = last_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule
`default_nettype wire

// File: tb/tb_stream_source_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_stream_source_gen
// Summary  : Scoreboard bench for stream_source_gen (two configurations).
// Revision : 1.0 - initial release
// ============================================================================
module tb_stream_source_gen;

`ifdef STREAM_SRC_GAP_EN
  localparam int GAP_EXP = 2;
`else
  localparam int GAP_EXP = 0;
`endif

  typedef struct packed {logic [7:0] d; logic l;} beat_t;

  logic clk = 1'b0;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  int   t_start = 0;
  int   hs_log[$];
  beat_t qa[$];
  beat_t qb[$];
  logic [1:0] stall_prev = 2'b00;

  logic       rst_a, start_a, ready_a, va, la, ba, done_a;
  logic [1:0] mode_a;
  logic [7:0] da;
  logic       rst_b, start_b, ready_b, vb, lb, bb, done_b;
  logic [1:0] mode_b;
  logic [7:0] db;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  stream_source_gen #(.WIDTH(8), .PKT_LEN(4), .NUM_PKTS(2), .SEED('hA5), .PKT_GAP(2)) u_dut_a (
    .clk(clk), .s_rst(rst_a), .start(start_a), .mode(mode_a), .ready(ready_a),
    .valid(va), .data_out(da), .last(la), .busy(ba), .done(done_a));

  stream_source_gen #(.WIDTH(8), .PKT_LEN(10), .NUM_PKTS(0), .SEED(1), .PKT_GAP(2)) u_dut_b (
    .clk(clk), .s_rst(rst_b), .start(start_b), .mode(mode_b), .ready(ready_b),
    .valid(vb), .data_out(db), .last(lb), .busy(bb), .done(done_b));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] lfsr_ref(input logic [15:0] s);
    return {s[14:0], ^(s & 16'hB400)};
  endfunction

  task automatic expect_run(input int k, input int m, input int n, input int plen, input logic [15:0] seed);
    logic [15:0] lf;
    logic [7:0]  d;
    lf = seed;
    for (int i = 1; i <= n; i++) begin
      case (m)
        0:       d = 8'(i);
        1:       d = seed[7:0];
        2:       d = 8'h01 << ((i - 1) % 8);
        default: d = lf[7:0];
      endcase
      lf = lfsr_ref(lf);
      if (k == 0) qa.push_back({d, (i % plen) == 0});
      else        qb.push_back({d, (i % plen) == 0});
    end
  endtask

  task automatic watch(input int k, input logic rst, input logic v, input logic r,
                       input logic [7:0] d, input logic l, input logic bsy);
    beat_t exp;
    int    depth;
    string pre;
    pre = (k == 0) ? "a" : "b";
    if (rst) begin
      stall_prev[k] = 1'b0;
      return;
    end
    depth = (k == 0) ? qa.size() : qb.size();
    if (stall_prev[k]) chk({pre, "_valid_held"}, v, 1);
    if (v) chk({pre, "_busy_with_valid"}, bsy, 1);
    if (v && depth > 0) begin
      exp = (k == 0) ? qa[0] : qb[0];
      chk({pre, r ? "_beat_data" : "_stall_data"}, d, exp.d);
      chk({pre, r ? "_beat_last" : "_stall_last"}, l, exp.l);
      if (r) begin
        if (k == 0) begin
          void'(qa.pop_front());
          hs_log.push_back(cyc);
        end else begin
          void'(qb.pop_front());
        end
      end
    end else if (v && r) begin
      n_vec++;
      n_err++;
      $display("FAIL %s_unexpected_beat: got data %0h with no beat expected (cycle %0d)", pre, d, cyc);
    end
    stall_prev[k] = v && !r;
  endtask

  always @(negedge clk) begin
    watch(0, rst_a, va, ready_a, da, la, ba);
    watch(1, rst_b, vb, ready_b, db, lb, bb);
  end

  task automatic pulse_start(input int k, input logic [1:0] m);
    @(posedge clk); #1;
    if (k == 0) begin mode_a = m; start_a = 1'b1; end
    else        begin mode_b = m; start_b = 1'b1; end
    t_start = cyc;
    @(posedge clk); #1;
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic wait_drain(input int k, input int budget);
    int n;
    n = 0;
    while (((k == 0) ? qa.size() : qb.size()) != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (((k == 0) ? qa.size() : qb.size()) != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain_timeout_%0d: %0d beats outstanding after %0d cycles, required 0",
               k, (k == 0) ? qa.size() : qb.size(), budget);
      if (k == 0) qa.delete(); else qb.delete();
    end
  endtask

  task automatic check_done_a();
    @(negedge clk);
    chk("a_done_set", done_a, 1);
    chk("a_valid_after_done", va, 0);
    chk("a_busy_after_done", ba, 0);
  endtask

  task automatic stop_b();
    #1 ready_b = 1'b0;
    @(posedge clk); #1 rst_b = 1'b1;
    @(posedge clk); #1 rst_b = 1'b0;
    ready_b = 1'b1;
    @(negedge clk);
    chk("b_valid_after_reset", vb, 0);
    chk("b_done_never_set", done_b, 0);
  endtask

  initial begin
    rst_a = 1'b1; start_a = 1'b0; ready_a = 1'b1; mode_a = 2'd0;
    rst_b = 1'b1; start_b = 1'b0; ready_b = 1'b1; mode_b = 2'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("a_rst_valid", va, 0);
    chk("a_rst_data", da, 0);
    chk("a_rst_last", la, 0);
    chk("a_rst_busy", ba, 0);
    chk("a_rst_done", done_a, 0);
    chk("b_rst_valid", vb, 0);
    @(posedge clk); #1 rst_a = 1'b0; rst_b = 1'b0;

    // full throughput, increment pattern
    expect_run(0, 0, 8, 4, 16'h0);
    hs_log.delete();
    pulse_start(0, 2'd0);
    wait_drain(0, 200);
    check_done_a();
    chk("a_hs_count", hs_log.size(), 8);
    if (hs_log.size() == 8) begin
      chk("a_first_beat_latency", hs_log[0] - t_start, 1);
      for (int i = 1; i < 8; i++)
        chk($sformatf("a_beat_spacing_%0d", i), hs_log[i] - hs_log[i-1], (i == 4) ? 1 + GAP_EXP : 1);
    end

    // backpressure at beat 3 for 5 cycles, with ignored start/mode mid-run
    expect_run(0, 0, 8, 4, 16'h0);
    pulse_start(0, 2'd0);
    @(negedge clk);
    chk("a_done_cleared", done_a, 0);
    chk("a_busy_in_run", ba, 1);
    @(posedge clk);
    @(posedge clk); #1 ready_a = 1'b0; start_a = 1'b1; mode_a = 2'd2;
    @(posedge clk); #1 start_a = 1'b0;
    repeat (4) @(posedge clk);
    #1 ready_a = 1'b1;
    wait_drain(0, 200);
    check_done_a();

    // constant and LFSR patterns with seed A5
    expect_run(0, 1, 8, 4, 16'h00A5);
    pulse_start(0, 2'd1);
    wait_drain(0, 200);
    check_done_a();
    expect_run(0, 3, 8, 4, 16'h00A5);
    pulse_start(0, 2'd3);
    wait_drain(0, 200);
    check_done_a();

    // reset while beat 3 is presented under backpressure
    expect_run(0, 0, 2, 4, 16'h0);
    pulse_start(0, 2'd0);
    @(posedge clk);
    @(posedge clk); #1 ready_a = 1'b0; rst_a = 1'b1;
    chk("a_beats_before_reset", qa.size(), 0);
    @(posedge clk);
    @(negedge clk);
    chk("a_midrst_valid", va, 0);
    chk("a_midrst_busy", ba, 0);
    chk("a_midrst_done", done_a, 0);
    chk("a_midrst_data", da, 0);
    chk("a_midrst_last", la, 0);
    @(posedge clk); #1 rst_a = 1'b0; ready_a = 1'b1;
    expect_run(0, 0, 8, 4, 16'h0);
    pulse_start(0, 2'd0);
    wait_drain(0, 200);
    check_done_a();

    // continuous instance: walking one, increment wrap, LFSR from seed 1
    expect_run(1, 2, 12, 10, 16'h1);
    pulse_start(1, 2'd2);
    wait_drain(1, 200);
    stop_b();
    expect_run(1, 0, 260, 10, 16'h1);
    pulse_start(1, 2'd0);
    wait_drain(1, 600);
    stop_b();
    expect_run(1, 3, 64, 10, 16'h1);
    pulse_start(1, 2'd3);
    wait_drain(1, 300);
    stop_b();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at time %0t, required completion", $time);
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/stream_source_gen.md
Name: stream_source_gen

Overview:
- Parametrised valid/ready test-traffic source; successor to the fixed-table single-stream source.
- Generates packets of PKT_LEN beats, with a selectable data pattern and a last flag, after a start pulse.
- Holds data stable under backpressure and signals completion.
- Sits at the upstream end of handshake benches and loopback paths, driving sinks/FIFOs under test.

Parameters:
- WIDTH, 8, data_out width in bits (1..32).
- PKT_LEN, 16, beats per packet (>=1).
- NUM_PKTS, 4, packets per run; 0 = continuous, never reaches DONE.
- SEED, 1, constant-mode value and LFSR seed (low 16 bits; a zero seed is replaced by 1).
- PKT_GAP, 2, idle cycles between packets (only used with STREAM_SRC_GAP_EN).

Ports:
- clk  in  1  clock.
- s_rst  in  1  reset, synchronous, active-high.
- start  in  1  begin a run; sampled only in IDLE or DONE.
- mode  in  2  pattern select, latched on accepted start.
- ready  in  1  downstream ready.
- valid  out  1  beat available.
- data_out  out  WIDTH  beat payload.
- last  out  1  final beat of the current packet.
- busy  out  1  high in RUN/GAP.
- done  out  1  high in DONE until next start or reset.

Behaviour:
- Reset:
  - state=IDLE; valid=0, last=0, busy=0, done=0, data_out=0.
  - Beat and packet counters=0; LFSR=SEED (1 if the seed is zero).
- All outputs are registered. Handshake = valid & ready at a rising edge.
- FSM states: IDLE, RUN, GAP, DONE.
- IDLE/DONE, start=1:
  - Latch mode; clear counters and done.
  - Load the first beat (pattern value 0); last=(PKT_LEN==1).
  - Next cycle: state=RUN, valid=1, busy=1.
- RUN:
  - valid stays 1; data_out and last are held unchanged while ready=0. valid never drops without a handshake.
  - On handshake, the next beat is loaded for the following cycle. Zero-bubble: back-to-back handshakes give one beat per cycle.
  - On handshake with last=1:
    - Increment the packet counter and clear the beat counter.
    - If NUM_PKTS!=0 and this was packet NUM_PKTS: next state DONE, valid=0, busy=0, done=1.
    - Otherwise stay in RUN (or go to GAP, see Optional Feature).
- Patterns (the sequence continues across packet boundaries within a run and restarts on each start):
  - mode 0, increment: 1,2,3,... modulo 2^WIDTH (wraps 2^WIDTH-1 -> 0).
  - mode 1, constant: SEED[WIDTH-1:0] every beat.
  - mode 2, walking one: 1, then rotate left by 1 each beat; wraps from the MSB back to bit 0.
  - mode 3, LFSR: 16-bit Fibonacci LFSR, x^16+x^14+x^13+x^11+1, shifted left once per handshake. data_out = LFSR[WIDTH-1:0] (zero-extended if WIDTH>16). The first beat is the seed.
- last = 1 exactly when the beat counter equals PKT_LEN-1.
- start asserted in RUN/GAP is ignored. mode changes mid-run are ignored.
- s_rst mid-run: all state returns to reset values next cycle, and the in-flight beat is discarded.
- NUM_PKTS=0: the source stays in RUN/GAP indefinitely; done is never set.

Optional Feature:
- Macro: STREAM_SRC_GAP_EN.
- Defined:
  - After the handshake of a last beat that does not finish the run, go to GAP.
  - In GAP: valid=0, busy=1, for exactly PKT_GAP cycles (PKT_GAP=0 behaves as undefined).
  - Then go to RUN with valid=1 and the next beat already loaded.
  - data_out holds its last value during the gap.
- Undefined: no GAP state; packets stream back-to-back, and the PKT_GAP parameter is ignored.

Test Plan:
- Full throughput: WIDTH=8, PKT_LEN=4, NUM_PKTS=2, mode 0, ready=1, start pulse -> data 1..8 on 8 consecutive cycles; last high on beats 4 and 8; done=1 the cycle after beat 8; valid=0 thereafter.
- Backpressure: same config, ready=0 for 5 cycles at beat 3 -> valid=1, data_out=3, last=0 held for all 5 cycles; sequence resumes with 4 (last=1) without loss or duplication.
- Walking one and wrap: mode 2, PKT_LEN=10, NUM_PKTS=1 -> 01,02,04,...,80,01,02; mode 0, NUM_PKTS=0, run 260 beats -> ...,FF,00,01.
- LFSR and constant: mode 3, SEED=1 -> first beats match the reference LFSR model for 64 beats; mode 1, SEED=8'hA5 -> every beat A5; start during RUN has no effect.
- Reset mid-run: assert s_rst at beat 2 of packet 1 -> next cycle valid=0, busy=0, done=0, data_out=0; a subsequent start restarts from data 1.
- Gap (STREAM_SRC_GAP_EN, PKT_GAP=2): PKT_LEN=4, NUM_PKTS=2, ready=1 -> valid low for exactly 2 cycles between beat 4 and beat 5; no gap after the final packet.
